pio_in_irq: RTL and testbench

- Parametrised Avalon-MM slave for general-purpose inputs (buttons, switches, LED-controller status) on the Nios II system bus.
- Successor to the plain read-only input port.
- Adds a 2-FF synchroniser, per-bit debounce, edge capture with write-1-to-clear, a per-bit IRQ mask and a level interrupt output.
- Readdata is registered, giving a read latency of 1 cycle.

---
 rtl/pio_in_pkg.sv | 22 ++
 rtl/pio_in_irq_if.sv | 21 ++
 rtl/pio_debounce_bit.sv | 45 ++++
 rtl/pio_in_irq.sv | 97 +++++++++
 tb/tb_pio_in_irq.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pio_in_pkg.sv
// rtl/pio_in_pkg.sv - shared constants and helpers for the PIO input block
package pio_in_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_RSVD    = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pio_in_irq_if.sv
// rtl/pio_in_irq_if.sv - register bus and interrupt signals of the PIO input block
interface pio_in_irq_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/pio_debounce_bit.sv
// rtl/pio_debounce_bit.sv - single-bit debounce filter on an already synchronised input
module pio_debounce_bit
  import pio_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic sync_in,
  output logic stable_out
);

  localparam int CW = (clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : clog2(DEBOUNCE_CYCLES + 1);

  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter only runs while the input disagrees with the held value, so any reversion restarts it.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (DEBOUNCE_CYCLES == 0) begin
      stable_d = sync_in;
    end else if (sync_in != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync_in;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_out = stable_q;

endmodule

// File: rtl/pio_in_irq.sv
// rtl/pio_in_irq.sv - debounced input port with edge capture, irq mask and level interrupt
module pio_in_irq
  import pio_in_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_MODE       = 0,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  pio_in_irq_if.slave      bus
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] ec_q, ec_d;
  logic [31:0]      rd_q, rd_d;
  logic             irq_q, irq_d;
  logic             wr_en;
  logic             unused_wd;

  assign wr_en     = bus.chipselect & ~bus.write_n;
  assign unused_wd = ^bus.writedata;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = in_port;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk       (clk),
      .reset     (reset),
      .sync_in   (sync_q[SYNC_STAGES-1][i]),
      .stable_out(stable[i])
    );
  end

  always_comb begin
    edge_ev = '0;
    case (EDGE_MODE)
      EDGE_FALL: edge_ev = ~stable & prev_q;
      EDGE_ANY:  edge_ev = stable ^ prev_q;
      default:   edge_ev = stable & ~prev_q;
    endcase
  end

  // A fresh edge is OR-ed in after the clear, so it survives a simultaneous write-1-to-clear.
  always_comb begin
    prev_d = stable;
    mask_d = mask_q;
    ec_d   = ec_q;
    if (wr_en && bus.address == ADDR_IRQMASK) mask_d = bus.writedata[WIDTH-1:0];
    if (wr_en && bus.address == ADDR_EDGECAP) ec_d = ec_q & ~bus.writedata[WIDTH-1:0];
    ec_d  = ec_d | edge_ev;
    irq_d = |(ec_d & mask_d);
    rd_d  = '0;
    case (bus.address)
      ADDR_DATA:    rd_d[WIDTH-1:0] = stable;
      ADDR_IRQMASK: rd_d[WIDTH-1:0] = mask_q;
      ADDR_EDGECAP: rd_d[WIDTH-1:0] = ec_q;
      default:      rd_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
      mask_q <= '0;
      ec_q   <= '0;
      rd_q   <= '0;
      irq_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      mask_q <= mask_d;
      ec_q   <= ec_d;
      rd_q   <= rd_d;
      irq_q  <= irq_d;
    end
  end

  assign bus.readdata = rd_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_pio_in_irq.sv
// tb/tb_pio_in_irq.sv - three configurations of pio_in_irq checked against a history-based reference model
module tb_pio_in_irq;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] pin = '0;
  logic [1:0]  address = '0;
  logic        cs = 1'b0;
  logic        wn = 1'b1;
  logic [31:0] wd = '0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pio_in_irq_if bus0 ();
  pio_in_irq_if bus1 ();
  pio_in_irq_if bus2 ();

  assign bus0.address = address;  assign bus0.chipselect = cs;
  assign bus0.write_n = wn;       assign bus0.writedata  = wd;
  assign bus1.address = address;  assign bus1.chipselect = cs;
  assign bus1.write_n = wn;       assign bus1.writedata  = wd;
  assign bus2.address = address;  assign bus2.chipselect = cs;
  assign bus2.write_n = wn;       assign bus2.writedata  = wd;

  pio_in_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(0), .EDGE_MODE(0), .SYNC_STAGES(S)) dut0 (
    .clk(clk), .reset(rst), .in_port(pin[7:0]), .bus(bus0.slave));
  pio_in_irq #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .SYNC_STAGES(S)) dut1 (
    .clk(clk), .reset(rst), .in_port(pin[7:0]), .bus(bus1.slave));
  pio_in_irq #(.WIDTH(12), .DEBOUNCE_CYCLES(0), .EDGE_MODE(2), .SYNC_STAGES(S)) dut2 (
    .clk(clk), .reset(rst), .in_port(pin), .bus(bus2.slave));

  int mw   [3] = '{8, 8, 12};
  int mdeb [3] = '{0, 4, 0};
  int mmode[3] = '{0, 0, 2};

  logic [31:0] m_stable[3], m_prev[3], m_ec[3], m_mask[3], m_rd[3];
  logic        m_irq[3];
  logic [31:0] vq[$];
  logic [31:0] sq[$];

  function automatic logic [31:0] dut_rd(int d);
    case (d)
      0: return bus0.readdata;
      1: return bus1.readdata;
      default: return bus2.readdata;
    endcase
  endfunction

  function automatic logic dut_irq(int d);
    case (d)
      0: return bus0.irq;
      1: return bus1.irq;
      default: return bus2.irq;
    endcase
  endfunction

  // Behaviour from the rules: sync is the pin S-1 edges back, a bit flips once its last N sync samples all disagree.
  task automatic model_step();
    logic [31:0] sync_new, wm, st, pv, ev, nst, mk, ec;
    bit wr_en, same;
    if (rst) begin
      vq = {};
      for (int i = 0; i < S - 1; i++) vq.push_front(32'd0);
      sq = {};
      for (int i = 0; i < 8; i++) sq.push_front(32'd0);
      for (int d = 0; d < 3; d++) begin
        m_stable[d] = '0; m_prev[d] = '0; m_ec[d] = '0;
        m_mask[d] = '0; m_rd[d] = '0; m_irq[d] = 1'b0;
      end
      return;
    end
    vq.push_front({20'd0, pin});
    sync_new = vq[S-1];
    while (vq.size() > S - 1) void'(vq.pop_back());
    wr_en = cs && !wn;
    for (int d = 0; d < 3; d++) begin
      wm = (32'd1 << mw[d]) - 32'd1;
      st = m_stable[d];
      pv = m_prev[d];
      case (mmode[d])
        1: ev = ~st & pv;
        2: ev = st ^ pv;
        default: ev = st & ~pv;
      endcase
      ev = ev & wm;
      if (mdeb[d] == 0) begin
        nst = sq[0] & wm;
      end else begin
        nst = st;
        for (int b = 0; b < mw[d]; b++) begin
          same = 1'b1;
          for (int j = 0; j < mdeb[d]; j++) if (sq[j][b] == st[b]) same = 1'b0;
          if (same) nst[b] = ~st[b];
        end
      end
      case (address)
        2'd0: m_rd[d] = st;
        2'd1: m_rd[d] = m_mask[d];
        2'd2: m_rd[d] = m_ec[d];
        default: m_rd[d] = 32'd0;
      endcase
      mk = m_mask[d];
      if (wr_en && address == 2'd1) mk = wd & wm;
      ec = m_ec[d];
      if (wr_en && address == 2'd2) ec = ec & ~wd;
      ec = (ec | ev) & wm;
      m_mask[d]   = mk;
      m_ec[d]     = ec;
      m_irq[d]    = |(ec & mk);
      m_prev[d]   = st;
      m_stable[d] = nst;
    end
    sq.push_front(sync_new);
    while (sq.size() > 8) void'(sq.pop_back());
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("model_rd%0d", d), dut_rd(d), m_rd[d]);
      chk($sformatf("model_irq%0d", d), {31'd0, dut_irq(d)}, {31'd0, m_irq[d]});
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] data);
    address = a; cs = 1'b1; wn = 1'b0; wd = data;
    tick();
    cs = 1'b0; wn = 1'b1; wd = $urandom;
  endtask

  initial begin
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      pin = 12'($urandom);
      address = 2'($urandom);
      tick();
    end

    pin = 12'h0A5;
    rst = 1'b1;
    tick();
    chk("reset_readdata", bus0.readdata, 32'd0);
    chk("reset_irq", {31'd0, bus0.irq}, 32'd0);
    rst = 1'b0;
    address = 2'd0;
    ticks(4);
    chk("data_after_reset", bus0.readdata, 32'h0000_00A5);
    address = 2'd2;
    tick();
    chk("edgecap_after_reset", bus0.readdata, 32'h0000_00A5);
    chk("irq_masked_after_reset", {31'd0, bus0.irq}, 32'd0);

    address = 2'd0;
    pin = 12'h000;
    ticks(12);
    pin = 12'h001;
    ticks(3);
    pin = 12'h000;
    ticks(4);
    chk("debounce_glitch_ignored", bus1.readdata, 32'd0);
    pin = 12'h001;
    ticks(12);
    chk("debounce_hold_rises", bus1.readdata, 32'd1);

    bus_write(2'd2, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'h0000_0001);
    pin = 12'h000;
    ticks(8);
    bus_write(2'd2, 32'hFFFF_FFFF);
    pin = 12'h001;
    ticks(5);
    address = 2'd2;
    tick();
    chk("edgecap_bit0", bus0.readdata, 32'h1);
    chk("irq_on_edge", {31'd0, bus0.irq}, 32'd1);
    bus_write(2'd2, 32'h1);
    chk("irq_cleared", {31'd0, bus0.irq}, 32'd0);

    pin = 12'h003;
    ticks(3);
    bus_write(2'd2, 32'h3);
    address = 2'd2;
    tick();
    chk("w1c_collision", bus0.readdata, 32'h2);

    bus_write(2'd1, 32'h0);
    pin = 12'h083;
    ticks(6);
    address = 2'd3;
    tick();
    chk("reserved_reads_0", bus0.readdata, 32'd0);
    chk("irq_gated_by_mask", {31'd0, bus0.irq}, 32'd0);
    bus_write(2'd1, 32'h80);
    chk("irq_after_mask_write", {31'd0, bus0.irq}, 32'd1);

    pin = 12'h800;
    ticks(10);
    bus_write(2'd2, 32'hFFFF_FFFF);
    ticks(2);
    pin = 12'h000;
    ticks(6);
    address = 2'd2;
    tick();
    chk("w12_any_fall", bus2.readdata, 32'h800);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 4) == 0) pin = 12'($urandom);
      address = 2'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        bus_write(2'($urandom), $urandom);
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
